// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
//   Output reordering stage for the radix-2 SDF FFT. Each frame of N = 2^LOG2N
//   complex samples arrives in bit-reversed order and leaves in natural order
//   (mode=0), or passes through unchanged (mode=1). Two ping-pong banks let
//   frames stream back-to-back.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   in_valid/in_ready     input handshake (in_ready = bank being written is free)
//   in_sop                first sample of an input frame (resyncs the writer)
//   in_re, in_im          input sample components, W bits each
//   mode                  0 = bit-reverse reorder, 1 = pass-through (per frame)
//   out_valid/out_ready   output handshake
//   out_re, out_im        output sample components
//   out_sop, out_eop      first / last sample of an output frame
//   sop_err               one-cycle pulse after an in_sop arrives mid-frame
module fft_bitrev_reorder #(
    parameter int LOG2N = 3,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sop,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         out_sop,
    output logic         out_eop,
    output logic         sop_err
);
    localparam int N = 1 << LOG2N;

    // Bank b occupies entries b*N .. b*N+N-1; address is {bank, index}.
    logic [2*W-1:0]   mem [0:2*N-1];

    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic [1:0]       bank_mode;
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;

    logic             wr_acc;
    logic             resync;
    logic [LOG2N-1:0] eff_cnt;
    logic             frame_mode;
    logic [LOG2N-1:0] wr_addr;
    logic             wr_last;
    logic             rd_load;
    logic             rd_last;
    logic [2*W-1:0]   rd_data;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    assign in_ready = !full[wr_bank];
    assign wr_acc   = in_valid && in_ready;
    assign resync   = wr_acc && in_sop && (wr_cnt != '0);

    // A resyncing sample restarts the frame, so it behaves exactly like index 0.
    assign eff_cnt    = resync ? '0 : wr_cnt;
    // The first sample of a frame uses the live mode, since bank_mode is only
    // being captured on that same edge.
    assign frame_mode = (eff_cnt == '0) ? mode : bank_mode[wr_bank];
    assign wr_addr    = frame_mode ? eff_cnt : bitrev(eff_cnt);
    assign wr_last    = &eff_cnt;

    assign rd_load = full[rd_bank] && (!out_valid || out_ready);
    assign rd_last = &rd_cnt;
    assign rd_data = mem[{rd_bank, rd_cnt}];

    // Fill and drain always touch different banks, so both updates can apply.
    always_comb begin
        full_nxt = full;
        if (wr_acc && wr_last) full_nxt[wr_bank] = 1'b1;
        if (rd_load && rd_last) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[{wr_bank, wr_addr}] <= {in_re, in_im};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= '0;
            bank_mode <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            sop_err   <= 1'b0;
        end else begin
            full    <= full_nxt;
            sop_err <= resync;

            if (wr_acc) begin
                if (eff_cnt == '0) bank_mode[wr_bank] <= mode;
                if (wr_last) begin
                    wr_bank <= !wr_bank;
                    wr_cnt  <= '0;
                end else begin
                    wr_cnt  <= eff_cnt + LOG2N'(1);
                end
            end

            if (rd_load) begin
                out_valid <= 1'b1;
                out_re    <= rd_data[2*W-1:W];
                out_im    <= rd_data[W-1:0];
                out_sop   <= (rd_cnt == '0);
                out_eop   <= rd_last;
                if (rd_last) begin
                    rd_bank <= !rd_bank;
                    rd_cnt  <= '0;
                end else begin
                    rd_cnt  <= rd_cnt + LOG2N'(1);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Testbench for fft_bitrev_reorder (LOG2N=3, W=16).
module tb_fft_bitrev_reorder;
    localparam int LOG2N = 3;
    localparam int W     = 16;
    localparam int N     = 1 << LOG2N;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         sop;
        logic         eop;
    } smp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_sop = 1'b0;
    logic [W-1:0] in_re = '0;
    logic [W-1:0] in_im = '0;
    logic         mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic         out_sop;
    logic         out_eop;
    logic         sop_err;

    int total = 0;
    int bad   = 0;

    smp_t         got_q[$];
    smp_t         exp_q[$];
    int           err_cnt = 0;
    int           low_cnt = 0;
    logic [W-1:0] fr_re [0:N-1];
    logic [W-1:0] fr_im [0:N-1];

    fft_bitrev_reorder #(.LOG2N(LOG2N), .W(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
        .in_re(in_re), .in_im(in_im), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im),
        .out_sop(out_sop), .out_eop(out_eop), .sop_err(sop_err)
    );

    always #5 clk = ~clk;

    // Record every output transfer and a few event counts; checks live in tasks.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) got_q.push_back('{out_re, out_im, out_sop, out_eop});
            if (sop_err) err_cnt++;
            if (!in_ready) low_cnt++;
        end
    end

    // Reference: output index j of a reordered frame carries input sample
    // k = bit-reverse of j, computed digit by digit with integer arithmetic.
    task automatic model_add(input bit md);
        int k, t;
        for (int j = 0; j < N; j++) begin
            if (md) k = j;
            else begin
                k = 0; t = j;
                for (int b = 0; b < LOG2N; b++) begin
                    k = k * 2 + (t % 2);
                    t = t / 2;
                end
            end
            exp_q.push_back('{fr_re[k], fr_im[k], (j == 0), (j == N - 1)});
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            fr_re[k] = W'($urandom_range(0, 65535));
            fr_im[k] = W'($urandom_range(0, 65535));
        end
    endtask

    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im,
                        input logic sop, input logic md);
        int c;
        in_valid = 1'b1; in_re = re; in_im = im; in_sop = sop; mode = md;
        c = 0;
        @(negedge clk);
        while (!in_ready && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 1000) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_sop = 1'b0;
    endtask

    task automatic send_frame(input bit md, input int toggle_at, input bit keep_valid);
        for (int k = 0; k < N; k++)
            send(fr_re[k], fr_im[k], (k == 0), (toggle_at >= 0 && k >= toggle_at) ? ~md : md);
        if (!keep_valid) in_valid = 1'b0;
        model_add(md);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_sop = 1'b0; out_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_out(input int base);
        for (int c = 0; c < 400 && got_q.size() < base + exp_q.size(); c++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%0b want=1", in_ready); end
        total++; if ({out_re, out_im, out_sop, out_eop, sop_err} !== '0)
            begin bad++; $display("FAIL reset_outputs: got=%h want=0", {out_re, out_im, out_sop, out_eop, sop_err}); end
    endtask

    task automatic test_bitrev();
        int base, e0;
        do_reset();
        exp_q.delete(); base = got_q.size(); e0 = err_cnt;
        for (int k = 0; k < N; k++) begin fr_re[k] = W'(k); fr_im[k] = W'(100 + k); end
        send_frame(1'b0, -1, 1'b0);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bitrev_early_valid: got=%0b want=0", out_valid); end
        @(negedge clk);
        total++; if ({out_valid, out_sop, out_re} !== {1'b1, 1'b1, W'(0)})
            begin bad++; $display("FAIL bitrev_latency: got v=%0b sop=%0b re=%0d want v=1 sop=1 re=0", out_valid, out_sop, out_re); end
        wait_out(base);
        total++; if (got_q.size() - base != exp_q.size()) begin bad++; $display("FAIL bitrev_count: got=%0d want=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            total++; if (got_q[base + i] !== exp_q[i]) begin bad++; $display("FAIL bitrev_data[%0d]: got=%h want=%h", i, got_q[base + i], exp_q[i]); end
        end
        total++; if (err_cnt != e0) begin bad++; $display("FAIL bitrev_sop_err: got=%0d pulses want=0", err_cnt - e0); end
    endtask

    task automatic test_natural_and_toggle();
        int base;
        do_reset();
        exp_q.delete(); base = got_q.size();
        fill_random();
        send_frame(1'b1, -1, 1'b0);
        fill_random();
        send_frame(1'b0, 4, 1'b0);
        wait_out(base);
        total++; if (got_q.size() - base != exp_q.size()) begin bad++; $display("FAIL nat_toggle_count: got=%0d want=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            total++; if (got_q[base + i] !== exp_q[i]) begin bad++; $display("FAIL nat_toggle_data[%0d]: got=%h want=%h", i, got_q[base + i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int base, l0;
        do_reset();
        exp_q.delete(); base = got_q.size(); l0 = low_cnt;
        fill_random(); send_frame(1'b0, -1, 1'b1);
        fill_random(); send_frame(1'b1, -1, 1'b1);
        fill_random(); send_frame(1'b0, -1, 1'b0);
        wait_out(base);
        total++; if (low_cnt != l0) begin bad++; $display("FAIL b2b_in_ready: got=%0d low cycles want=0", low_cnt - l0); end
        total++; if (got_q.size() - base != exp_q.size()) begin bad++; $display("FAIL b2b_count: got=%0d want=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            total++; if (got_q[base + i] !== exp_q[i]) begin bad++; $display("FAIL b2b_data[%0d]: got=%h want=%h", i, got_q[base + i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int base, hi_early, c;
        do_reset();
        exp_q.delete();
        out_ready = 1'b0;
        fill_random(); send_frame(1'b0, -1, 1'b1);
        fill_random(); send_frame(1'b1, -1, 1'b0);
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_low: got=%0b want=0", in_ready); end
        total++; if ({out_valid, out_sop, out_re, out_im} !== {1'b1, 1'b1, exp_q[0].re, exp_q[0].im})
            begin bad++; $display("FAIL bp_stall_head: got=%h want=%h", {out_valid, out_sop, out_re, out_im}, {1'b1, 1'b1, exp_q[0].re, exp_q[0].im}); end
        @(posedge clk);
        #1;
        base = got_q.size();
        out_ready = 1'b1;
        hi_early = 0; c = 0;
        @(negedge clk);
        while (!(out_valid && out_eop) && c < 100) begin
            if (in_ready) hi_early++;
            @(negedge clk);
            c++;
        end
        total++; if (in_ready !== 1'b1 || c >= 100) begin bad++; $display("FAIL bp_in_ready_return: got=%0b want=1", in_ready); end
        total++; if (hi_early != 0) begin bad++; $display("FAIL bp_in_ready_early: got=%0d cycles want=0", hi_early); end
        wait_out(base);
        total++; if (got_q.size() - base != exp_q.size()) begin bad++; $display("FAIL bp_count: got=%0d want=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            total++; if (got_q[base + i] !== exp_q[i]) begin bad++; $display("FAIL bp_data[%0d]: got=%h want=%h", i, got_q[base + i], exp_q[i]); end
        end
    endtask

    task automatic test_resync();
        int base, e0;
        do_reset();
        exp_q.delete(); base = got_q.size(); e0 = err_cnt;
        for (int k = 0; k < 3; k++) send(W'(k), W'($urandom_range(0, 65535)), (k == 0), 1'b0);
        for (int k = 0; k < N; k++) begin fr_re[k] = W'(50 + k); fr_im[k] = W'($urandom_range(0, 65535)); end
        send_frame(1'b0, -1, 1'b0);
        wait_out(base);
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL resync_sop_err: got=%0d pulses want=1", err_cnt - e0); end
        total++; if (got_q.size() - base != exp_q.size()) begin bad++; $display("FAIL resync_count: got=%0d want=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            total++; if (got_q[base + i] !== exp_q[i]) begin bad++; $display("FAIL resync_data[%0d]: got=%h want=%h", i, got_q[base + i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midreadout();
        int base, idx, c;
        do_reset();
        exp_q.delete();
        fill_random(); send_frame(1'b0, -1, 1'b0);
        idx = 0; c = 0;
        while (idx < 5 && c < 100) begin
            @(negedge clk);
            if (out_valid) idx++;
            c++;
        end
        reset = 1'b1;
        #1;
        total++; if ({out_valid, out_sop, in_ready} !== 3'b001)
            begin bad++; $display("FAIL midreset_flags: got v=%0b sop=%0b rdy=%0b want v=0 sop=0 rdy=1", out_valid, out_sop, in_ready); end
        total++; if ({out_re, out_im} !== '0) begin bad++; $display("FAIL midreset_data: got=%h want=0", {out_re, out_im}); end
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete(); base = got_q.size();
        fill_random(); send_frame(1'b0, -1, 1'b0);
        wait_out(base);
        total++; if (got_q.size() - base != exp_q.size()) begin bad++; $display("FAIL midreset_count: got=%0d want=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            total++; if (got_q[base + i] !== exp_q[i]) begin bad++; $display("FAIL midreset_data[%0d]: got=%h want=%h", i, got_q[base + i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_bitrev();
        test_natural_and_toggle();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_reset_midreadout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Parametrised output-reordering stage for the radix-2 SDF FFT pipeline. It sits after the last butterfly stage and turns each bit-reversed-order frame of 2^LOG2N complex samples into natural order, or passes frames through unchanged in bypass mode. It replaces the single fixed-size shuffle buffer with ping-pong banks, so frames stream back-to-back. A valid/ready handshake on both sides, frame markers and a resync/error flag are added.

## Interface
- LOG2N, default 3: log2 of frame length; N = 2^LOG2N, legal 1..10.
- W, default 16: width of each real/imag component, two's complement, carried unmodified.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept a sample; combinational, equals !full[wr_bank].
- in_sop  in  1  marks sample index 0 of a frame; qualified by in_valid&&in_ready.
- in_re, in_im  in  W each  input sample.
- mode  in  1  0 = bit-reverse reorder, 1 = natural pass-through; sampled per frame.
- out_valid  out  1  output register holds a sample.
- out_ready  in  1  downstream accepts the sample when out_valid&&out_ready.
- out_re, out_im  out  W each  output sample.
- out_sop, out_eop  out  1 each  first / last sample of an output frame.
- sop_err  out  1  one-cycle pulse: in_sop accepted while wr_cnt != 0.

## Operation
- Storage: two banks, each N entries of 2W bits. State: wr_bank, rd_bank, full[1:0], wr_cnt and rd_cnt (LOG2N bits each), bank_mode[1:0].
- Write accept: in_valid && in_ready.
  - Write address = bitrev(wr_cnt) if the frame mode is 0, else wr_cnt.
  - bank_mode[wr_bank] latches `mode` on the accept where wr_cnt==0. `mode` changes mid-frame are ignored.
  - On the accept with wr_cnt==N-1: set full[wr_bank], toggle wr_bank, clear wr_cnt. Otherwise wr_cnt+1.
- Resync: in_sop accepted with wr_cnt!=0.
  - The partial frame is discarded.
  - The sample is written as index 0 of a new frame in the same bank. Mode is re-latched, wr_cnt becomes 1, and sop_err pulses the next cycle.
  - in_sop with wr_cnt==0 is normal. Frames without in_sop are delimited by the counter alone.
- Read load: occurs when full[rd_bank] && (!out_valid || out_ready).
  - Output register <= bank[rd_bank][rd_cnt]; out_valid <= 1.
  - out_sop <= (rd_cnt==0); out_eop <= (rd_cnt==N-1).
  - On rd_cnt==N-1: clear full[rd_bank], toggle rd_bank, clear rd_cnt. Otherwise rd_cnt+1.
- If there is no load and out_valid&&out_ready: out_valid <= 0. Output data holds its value while out_valid && !out_ready.
- Simultaneous events:
  - Setting full on one bank and clearing it on the other in the same cycle are independent.
  - A write never targets a full bank.
  - The bank being read is always full, so a read never sees a partial frame.
- Reset:
  - out_valid=0; out_re=out_im=0; out_sop=out_eop=0; sop_err=0.
  - full=0, so in_ready=1 after reset.
  - Counters, bank pointers and bank_mode are 0.
  - Reset mid-frame or mid-readout discards all buffered data.

## Timing
- Latency: last sample of a frame accepted at edge t → out_valid high after edge t+1 with index 0 (out_sop=1).
- Throughput: with out_ready held at 1, one sample per cycle in and out, sustained indefinitely. in_ready never drops.
- Backpressure: with out_ready=0, in_ready falls the cycle after the second full frame is written. It rises the cycle after the read side frees a bank, i.e. the edge that loads index N-1 of the draining frame.
- Memory read is combinational or pre-addressed so the above latency holds. Any RAM mapping must preserve it.
- sop_err is registered: high for exactly one cycle after the offending accept edge.

## Test plan
- LOG2N=3, mode=0: feed re=k, im=100+k for k=0..7, in_sop at k=0, out_ready=1 → out_re sequence 0,4,2,6,1,5,3,7 with im = re+100. out_sop on the first output, out_eop on the last, first out_valid one cycle after the k=7 accept.
- Same stimulus, mode=1 → out_re 0..7 in order. Toggling mode at k=4 within a mode=0 frame still gives 0,4,2,6,1,5,3,7.
- Three back-to-back frames, alternating mode 0/1/0, out_ready=1 → in_ready stays 1. 24 contiguous outputs, each frame correctly ordered, out_sop/out_eop every 8 samples.
- out_ready=0, stream continuously → in_ready=0 after 16 accepts and out_valid stuck at index 0 of frame 0. Raise out_ready → frame 0 then frame 1 drain intact, in_ready returns 1 after frame 0's last load.
- in_sop asserted at k=3 of a frame, then 8 more samples with values 50..57 → sop_err pulses once. The output frame is the reorder of 50..57; the partial values 0..2 never appear.
- Assert reset mid-readout at output index 4 → out_valid=0, out_sop=0, in_ready=1 immediately. A new frame afterwards reorders correctly with no stale data.
